// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and fixed AXI constants for the sram-like to AXI3 bridge.
// Every transfer is a single beat, so the burst fields never change.
package axi_bridge_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_AR   = 2'd1,
        R_R    = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_AW_W = 2'd1,
        W_B    = 2'd2
    } wr_state_e;

    localparam logic [3:0] INST_ID   = 4'd0;
    localparam logic [3:0] DATA_ID   = 4'd1;

    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [1:0] AXI_BURST = 2'b01;
    localparam logic [1:0] AXI_LOCK  = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'b0000;
    localparam logic [2:0] AXI_PROT  = 3'b000;

    // sram-like size is log2(bytes) in two bits; AXI uses three.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI3 master port of the bridge, single-beat subset.
// master = the bridge, slave = the interconnect or a memory model.
interface sram_axi_bridge_if;

    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;

    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_wr_channel.sv
// Write side of the bridge: sequences AW and W independently, then waits on B.
// Only the data port writes, so AWID/WID are always DATA_ID.
module axi_wr_channel
    import axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_accept,
    input  logic [1:0]  wr_size,
    input  logic [31:0] wr_addr,
    input  logic [3:0]  wr_strb,
    input  logic [31:0] wr_data,
    output logic        w_idle,
    output logic        wr_done,
    sram_axi_bridge_if.master axi
);

    wr_state_e   state, state_nxt;
    logic        aw_done_q, w_done_q;
    logic        aw_hs, w_hs, both_done;
    logic [31:0] awaddr_q, wdata_q;
    logic [2:0]  awsize_q;
    logic [3:0]  wstrb_q;

    assign aw_hs     = axi.awvalid && axi.awready;
    assign w_hs      = axi.wvalid && axi.wready;
    assign both_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= W_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            W_IDLE:  if (wr_accept)   state_nxt = W_AW_W;
            W_AW_W:  if (both_done)   state_nxt = W_B;
            W_B:     if (axi.bvalid)  state_nxt = W_IDLE;
            default:                  state_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        w_idle      = (state == W_IDLE);
        axi.awvalid = (state == W_AW_W) && !aw_done_q;
        axi.wvalid  = (state == W_AW_W) && !w_done_q;
        axi.bready  = (state == W_B);
        wr_done     = (state == W_B) && axi.bvalid && !reset;
    end

    // Each channel drops its valid as soon as its own handshake completes.
    always_ff @(posedge clk) begin
        if (reset || state != W_AW_W || both_done) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            aw_done_q <= aw_done_q || aw_hs;
            w_done_q  <= w_done_q || w_hs;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            awaddr_q <= '0;
            awsize_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else if (wr_accept) begin
            awaddr_q <= wr_addr;
            awsize_q <= axi_size(wr_size);
            wdata_q  <= wr_data;
            wstrb_q  <= wr_strb;
        end
    end

    assign axi.awid    = DATA_ID;
    assign axi.awaddr  = awaddr_q;
    assign axi.awsize  = awsize_q;
    assign axi.awlen   = AXI_LEN;
    assign axi.awburst = AXI_BURST;
    assign axi.awlock  = AXI_LOCK;
    assign axi.awcache = AXI_CACHE;
    assign axi.awprot  = AXI_PROT;
    assign axi.wid     = DATA_ID;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = 1'b1;

endmodule

// File: rtl/sram_axi_bridge.sv
// Merges the fetch and data sram-like ports onto one AXI3 master.
// Reads share AR/R (steered back by ID); writes come from the data port only.
module sram_axi_bridge
    import axi_bridge_pkg::*;
(
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    sram_axi_bridge_if.master axi
);

    rd_state_e   r_state, r_state_nxt;
    logic [3:0]  ar_id_q;
    logic [31:0] ar_addr_q;
    logic [2:0]  ar_size_q;
    logic        inst_prio_q;

    logic        r_idle, w_idle, wr_done;
    logic        inst_first, data_rd_busy;
    logic        data_rd_accept, data_wr_accept, inst_accept, rd_accept;
    logic        rd_done;

    assign r_idle       = (r_state == R_IDLE);
    assign data_rd_busy = !r_idle && (ar_id_q == DATA_ID);
    // A fetch that lost arbitration once wins the next free slot.
    assign inst_first   = inst_prio_q && inst_req;

    assign data_rd_accept = !reset && data_req && !data_wr && r_idle && w_idle
                            && !inst_first;
    assign data_wr_accept = !reset && data_req && data_wr && w_idle && !data_rd_busy
                            && !inst_first;
    assign inst_accept    = !reset && inst_req && r_idle && w_idle
                            && !data_rd_accept && !data_wr_accept;
    assign rd_accept      = data_rd_accept || inst_accept;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (rd_accept)   r_state_nxt = R_AR;
            R_AR:    if (axi.arready) r_state_nxt = R_R;
            R_R:     if (axi.rvalid)  r_state_nxt = R_IDLE;
            default:                  r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        axi.arvalid  = (r_state == R_AR);
        axi.rready   = (r_state == R_R);
        rd_done      = (r_state == R_R) && axi.rvalid && !reset;
        inst_addr_ok = inst_accept;
        data_addr_ok = data_rd_accept || data_wr_accept;
        inst_data_ok = rd_done && (axi.rid == INST_ID);
        data_data_ok = (rd_done && (axi.rid == DATA_ID)) || wr_done;
        inst_rdata   = axi.rdata;
        data_rdata   = axi.rdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ar_id_q   <= INST_ID;
            ar_addr_q <= '0;
            ar_size_q <= '0;
        end else if (rd_accept) begin
            ar_id_q   <= data_rd_accept ? DATA_ID : INST_ID;
            ar_addr_q <= data_rd_accept ? data_addr : inst_addr;
            ar_size_q <= axi_size(data_rd_accept ? data_size : inst_size);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inst_prio_q <= 1'b0;
        end else if (inst_accept) begin
            inst_prio_q <= 1'b0;
        end else if ((data_rd_accept || data_wr_accept) && inst_req) begin
            inst_prio_q <= 1'b1;
        end
    end

    assign axi.arid    = ar_id_q;
    assign axi.araddr  = ar_addr_q;
    assign axi.arsize  = ar_size_q;
    assign axi.arlen   = AXI_LEN;
    assign axi.arburst = AXI_BURST;
    assign axi.arlock  = AXI_LOCK;
    assign axi.arcache = AXI_CACHE;
    assign axi.arprot  = AXI_PROT;

    axi_wr_channel u_wr (
        .clk       (clk),
        .reset     (reset),
        .wr_accept (data_wr_accept),
        .wr_size   (data_size),
        .wr_addr   (data_addr),
        .wr_strb   (data_wstrb),
        .wr_data   (data_wdata),
        .w_idle    (w_idle),
        .wr_done   (wr_done),
        .axi       (axi)
    );

    // The fetch port never writes, and response codes/IDs on B are not used.
    logic unused_ok;
    assign unused_ok = ^{inst_wr, inst_wstrb, inst_wdata, axi.rresp, axi.rlast,
                         axi.bid, axi.bresp};

endmodule
